profile_gen_mc: RTL and testbench
=================================

// Module: profile_gen_mc
// PURPOSE
//  Parametrised multi-channel jerk-integrating velocity profile generator, successor of the 8-channel engine.
//  Each channel has a 64-bit register file (JJ->J->A->V chain) that the host loads through the param port.
//  On every acc_step the block walks all channels and integrates them with saturating arithmetic.
//  It publishes a packed per-channel effective speed to the step generators and handles target-velocity stops and host aborts.
// PARAMETERS
//  CHANNELS    8   number of axes, 1..16; CH_BITS = max(1, clog2(CHANNELS))
//  SPEED_BITS  64  width of each speed output slice, <= 64; value is the low bits of V_EFF
//  STEP_CYC    16  max engine cycles per enabled channel; the busy time bound derives from it
// PORTS
//  clk             in   1                      system clock
//  rst_n           in   1                      asynchronous active-low reset
//  acc_step        in   1                      pulse: start one integration pass over all channels
//  busy            out  1                      pass in progress
//  done            out  1                      1-cycle pulse at end of pass
//  step_overrun    out  1                      1-cycle pulse: acc_step arrived while busy, step dropped
//  speed           out  CHANNELS*SPEED_BITS    packed V_EFF per channel, ch0 in the LSBs
//  param_addr      in   CH_BITS+4              {channel, reg[3:0]}
//  param_in        in   32                     host write data
//  param_write_lo  in   1                      write param_in to bits [31:0] of the addressed register
//  param_write_hi  in   1                      write param_in to bits [63:32] of the addressed register
//  param_out       out  64                     addressed register, 1-cycle read latency
//  abort           in   CHANNELS               pulse per channel: request decel to zero
//  pending_aborts  out  CHANNELS               accepted and not yet completed aborts
//  done_aborts     out  CHANNELS               1-cycle pulse when an abort completes
//  sat_flags       out  CHANNELS               sticky: a saturation occurred on this channel
//  sat_clear       in   1                      clears all sat_flags
// BEHAVIOUR
//  - Registers per channel (all signed 64-bit): 0 STATUS (bit0 ENABLE, bit1 TARGET_V), 1 V_EFF, 2 V_IN, 3 V_OUT,
//    4 A, 5 J, 6 JJ, 7 TARGET_V, 8 ABORT_A. Addresses 9..15 are plain storage. Storage is not reset.
//  - Reset (async, rst_n=0): busy, done, step_overrun, speed, pending_aborts, done_aborts and sat_flags go to 0;
//    the FSM goes to IDLE. A pass in progress is abandoned with partial register writes, which is allowed.
//  - FSM: IDLE -> (acc_step) RD_STATUS -> {SKIP | ABORT_SETUP | INTEGRATE} -> NEXT -> RD_STATUS of ch+1,
//    or IDLE after the last channel. done pulses in the cycle busy falls.
//  - busy rises in the cycle after acc_step. A pass finishes within CHANNELS*STEP_CYC+2 cycles.
//  - acc_step while busy: the step is dropped and step_overrun pulses; the pass in progress is unaffected.
//  - Disabled channel (ENABLE=0): no register writes, speed slice holds its value.
//    If the channel has a pending abort, it completes at once: done_aborts pulses and the pending bit clears.
//  - INTEGRATE, with sat() clamping to [-2^63, 2^63-1] and each clamp setting sat_flags[ch]:
//    J' = sat(J+JJ); A' = sat(A+J'); V_IN = V_OUT; Vn = sat(V_OUT+A').
//  - TARGET_V=1 and TARGET_V lies between V_OUT and Vn inclusive: Vn = TARGET_V, and A, J, JJ are written 0.
//  - Then V_OUT = Vn; V_EFF = (V_OUT_old + Vn) >>> 1, from a 65-bit sum so it never overflows.
//    speed[ch] takes V_EFF[SPEED_BITS-1:0] in the same cycle as the V_EFF write.
//  - abort[ch] sets pending_aborts[ch] (OR-accumulate). A set and a completion in the same cycle: completion wins.
//  - ABORT_SETUP: runs on the first visit of an enabled channel with pending set and not yet in progress.
//    Writes JJ=J=TARGET_V=0 and sets STATUS.TARGET_V.
//    A = -V_OUT if ABORT_A==0; otherwise -|ABORT_A|*sign(V_OUT), and A=0 if V_OUT==0. Marks in progress.
//    The same channel then runs INTEGRATE in this pass.
//  - An abort in progress completes when INTEGRATE clamps V_OUT to exactly 0 (done_aborts pulse, pending clears).
//    A host clear of ENABLE also completes it, on the next visit.
//  - Host writes: lo/hi may be asserted together. If the engine writes the same register in the same cycle,
//    the engine write wins. Host writes to registers of the channel being integrated give undefined results
//    for that pass only.
//  - sat_clear and a new saturation in the same cycle: the flag stays set.
// TESTING
//  1 ch0 ENABLE, V_OUT=0, A=0, J=0, JJ=10, 3 steps -> V_OUT=10,40,100; speed slice 0 = 5,25,70.
//  2 ch2 ENABLE|TARGET_V, V_OUT=90, A=20, TARGET_V=100, 1 step -> V_OUT=100, A=J=JJ=0, V_EFF=95.
//  3 ch1 V_OUT=1000, ABORT_A=300, abort[1] pulse -> V_OUT 700,400,100,0; done_aborts[1] pulses on the 4th step.
//  4 ch3 V_OUT=2^63-5, A=100 -> V_OUT=2^63-1, sat_flags[3]=1; sat_clear -> 0.
//  5 acc_step asserted 3 cycles after a previous acc_step -> step_overrun pulses, exactly one done.
//  6 rst_n low mid-pass -> all outputs 0 immediately; the next acc_step runs a full, normal pass.

Source files
------------

// File: rtl/profile_gen_mc.sv
// Multi-channel jerk-integrating velocity profile generator.
// Each acc_step walks every channel's JJ->J->A->V register chain with saturating arithmetic.
module profile_gen_mc #(
  parameter int CHANNELS   = 8,
  parameter int SPEED_BITS = 64,
  parameter int STEP_CYC   = 16,
  localparam int CH_BITS   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           acc_step,
  output logic                           busy,
  output logic                           done,
  output logic                           step_overrun,
  output logic [CHANNELS*SPEED_BITS-1:0] speed,
  input  logic [CH_BITS+3:0]             param_addr,
  input  logic [31:0]                    param_in,
  input  logic                           param_write_lo,
  input  logic                           param_write_hi,
  output logic [63:0]                    param_out,
  input  logic [CHANNELS-1:0]            abort,
  output logic [CHANNELS-1:0]            pending_aborts,
  output logic [CHANNELS-1:0]            done_aborts,
  output logic [CHANNELS-1:0]            sat_flags,
  input  logic                           sat_clear
);

  localparam int DEPTH = 1 << (CH_BITS + 4);
  localparam logic [63:0] S64_MAX = 64'h7fff_ffff_ffff_ffff;
  localparam logic [63:0] S64_MIN = 64'h8000_0000_0000_0000;

  localparam logic [3:0] R_STATUS  = 4'd0;
  localparam logic [3:0] R_V_EFF   = 4'd1;
  localparam logic [3:0] R_V_IN    = 4'd2;
  localparam logic [3:0] R_V_OUT   = 4'd3;
  localparam logic [3:0] R_A       = 4'd4;
  localparam logic [3:0] R_J       = 4'd5;
  localparam logic [3:0] R_JJ      = 4'd6;
  localparam logic [3:0] R_TARGET  = 4'd7;
  localparam logic [3:0] R_ABORT_A = 4'd8;

  // Each channel takes at most four engine cycles (RD_STATUS, ABORT_SETUP, INTEGRATE, NEXT).
  if (STEP_CYC < 4 || CHANNELS < 1 || CHANNELS > 16 || SPEED_BITS < 1 || SPEED_BITS > 64) begin : g_param_check
    $error("profile_gen_mc: unsupported parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_RD_STATUS, S_SKIP, S_ABORT_SETUP, S_INTEGRATE, S_NEXT
  } state_t;

  state_t state, state_next;
  logic [CH_BITS-1:0]  ch, ch_next;
  logic [CHANNELS-1:0] ch_onehot, in_prog, complete;
  logic                done_set, pend_hit, prog_hit, sat_event, tgt_hit;

  logic [63:0] regs [0:DEPTH-1];

  function automatic logic [CH_BITS+3:0] ra(input logic [CH_BITS-1:0] c, input logic [3:0] r);
    return {c, r};
  endfunction

  // Returns {clamped, value}.
  function automatic logic [64:0] sat_add(input logic signed [63:0] x, input logic signed [63:0] y);
    logic signed [64:0] s;
    s = {x[63], x} + {y[63], y};
    if (s[64] != s[63]) return {1'b1, (s[64] ? S64_MIN : S64_MAX)};
    return {1'b0, s[63:0]};
  endfunction

  logic signed [63:0] status_r, v_out_r, a_r, j_r, jj_r, tv_r, abort_a_r;
  logic signed [63:0] abs_abort, a_abort, j_new, a_new, v_int, v_lo, v_hi, v_new, v_eff;
  logic signed [64:0] veff_sum;
  logic [64:0]        jr, ar, vr;

  always_comb begin
    status_r  = regs[ra(ch, R_STATUS)];
    v_out_r   = regs[ra(ch, R_V_OUT)];
    a_r       = regs[ra(ch, R_A)];
    j_r       = regs[ra(ch, R_J)];
    jj_r      = regs[ra(ch, R_JJ)];
    tv_r      = regs[ra(ch, R_TARGET)];
    abort_a_r = regs[ra(ch, R_ABORT_A)];

    abs_abort = abort_a_r[63] ? -abort_a_r : abort_a_r;
    if (abort_a_r == '0)      a_abort = -v_out_r;
    else if (v_out_r == '0)   a_abort = '0;
    else if (v_out_r[63])     a_abort = abs_abort;
    else                      a_abort = -abs_abort;

    jr    = sat_add(j_r, jj_r);
    j_new = jr[63:0];
    ar    = sat_add(a_r, j_new);
    a_new = ar[63:0];
    vr    = sat_add(v_out_r, a_new);
    v_int = vr[63:0];

    v_lo    = (v_out_r < v_int) ? v_out_r : v_int;
    v_hi    = (v_out_r < v_int) ? v_int : v_out_r;
    tgt_hit = status_r[1] && (tv_r >= v_lo) && (tv_r <= v_hi);
    v_new   = tgt_hit ? tv_r : v_int;

    veff_sum  = {v_out_r[63], v_out_r} + {v_new[63], v_new};
    v_eff     = veff_sum[64:1];
    sat_event = (state == S_INTEGRATE) && (jr[64] || ar[64] || vr[64]);
  end

  always_comb begin
    ch_onehot = CHANNELS'(1) << ch;
    pend_hit  = |(pending_aborts & ch_onehot);
    prog_hit  = |(in_prog & ch_onehot);
    busy      = (state != S_IDLE);
  end

  always_comb begin
    state_next = state;
    ch_next    = ch;
    complete   = '0;
    done_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (acc_step) begin
          state_next = S_RD_STATUS;
          ch_next    = '0;
        end
      end
      S_RD_STATUS: begin
        if (!status_r[0])              state_next = S_SKIP;
        else if (pend_hit && !prog_hit) state_next = S_ABORT_SETUP;
        else                           state_next = S_INTEGRATE;
      end
      S_SKIP: begin
        if (pend_hit) complete = ch_onehot;
        state_next = S_NEXT;
      end
      S_ABORT_SETUP: state_next = S_INTEGRATE;
      S_INTEGRATE: begin
        if (prog_hit && tgt_hit && v_new == '0) complete = ch_onehot;
        state_next = S_NEXT;
      end
      S_NEXT: begin
        if (ch == CH_BITS'(CHANNELS - 1)) begin
          state_next = S_IDLE;
          done_set   = 1'b1;
        end else begin
          ch_next    = ch + 1'b1;
          state_next = S_RD_STATUS;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      ch             <= '0;
      done           <= 1'b0;
      step_overrun   <= 1'b0;
      speed          <= '0;
      pending_aborts <= '0;
      in_prog        <= '0;
      done_aborts    <= '0;
      sat_flags      <= '0;
    end else begin
      state          <= state_next;
      ch             <= ch_next;
      done           <= done_set;
      step_overrun   <= acc_step && (state != S_IDLE);
      pending_aborts <= (pending_aborts | abort) & ~complete;
      in_prog        <= (in_prog | ((state == S_ABORT_SETUP) ? ch_onehot : '0)) & ~complete;
      done_aborts    <= complete;
      sat_flags      <= (sat_clear ? '0 : sat_flags) | (sat_event ? ch_onehot : '0);
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (state == S_INTEGRATE && ch_onehot[i])
          speed[i*SPEED_BITS +: SPEED_BITS] <= v_eff[SPEED_BITS-1:0];
      end
    end
  end

  // Register file is not reset; engine writes follow host writes so the engine wins a collision.
  always_ff @(posedge clk) begin
    if (param_write_lo) regs[param_addr][31:0]  <= param_in;
    if (param_write_hi) regs[param_addr][63:32] <= param_in;
    case (state)
      S_ABORT_SETUP: begin
        regs[ra(ch, R_JJ)]     <= '0;
        regs[ra(ch, R_J)]      <= '0;
        regs[ra(ch, R_TARGET)] <= '0;
        regs[ra(ch, R_A)]      <= a_abort;
        regs[ra(ch, R_STATUS)] <= status_r | 64'd2;
      end
      S_INTEGRATE: begin
        regs[ra(ch, R_JJ)]    <= tgt_hit ? '0 : jj_r;
        regs[ra(ch, R_J)]     <= tgt_hit ? '0 : j_new;
        regs[ra(ch, R_A)]     <= tgt_hit ? '0 : a_new;
        regs[ra(ch, R_V_IN)]  <= v_out_r;
        regs[ra(ch, R_V_OUT)] <= v_new;
        regs[ra(ch, R_V_EFF)] <= v_eff;
      end
      default: ;
    endcase
    param_out <= regs[param_addr];
  end

endmodule

// File: tb/tb_profile_gen_mc.sv
// Scoreboard bench for profile_gen_mc: expectations queued per pass, drained after done.
module tb_profile_gen_mc;
  localparam int NCH = 4;
  localparam int SB  = 64;
  localparam int K_SPEED = -1, K_SAT = -2, K_DAB = -3, K_PEND = -4;

  logic clk = 1'b0, rst_n = 1'b0, acc_step = 1'b0, sat_clear = 1'b0;
  logic busy, done, step_overrun;
  logic param_write_lo = 1'b0, param_write_hi = 1'b0;
  logic [NCH*SB-1:0] speed;
  logic [5:0]  param_addr = '0;
  logic [31:0] param_in = '0;
  logic [63:0] param_out;
  logic [NCH-1:0] abort = '0, pending_aborts, done_aborts, sat_flags;

  profile_gen_mc #(.CHANNELS(NCH), .SPEED_BITS(SB), .STEP_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .acc_step(acc_step), .busy(busy), .done(done),
    .step_overrun(step_overrun), .speed(speed), .param_addr(param_addr),
    .param_in(param_in), .param_write_lo(param_write_lo), .param_write_hi(param_write_hi),
    .param_out(param_out), .abort(abort), .pending_aborts(pending_aborts),
    .done_aborts(done_aborts), .sat_flags(sat_flags), .sat_clear(sat_clear)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; int ch; int r; logic [63:0] val; } exp_t;
  exp_t sb[$];

  int total = 0, bad = 0;
  int done_cnt = 0, ovr_cnt = 0;
  int dab_cnt [NCH] = '{default: 0};

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (step_overrun) ovr_cnt++;
    for (int i = 0; i < NCH; i++) if (done_aborts[i]) dab_cnt[i]++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input int c, input int r, input logic [63:0] v);
    sb.push_back('{tag, c, r, v});
  endtask

  task automatic wr64(input int c, input int r, input logic [63:0] v);
    param_addr = 6'(c*16 + r);
    param_in = v[31:0]; param_write_lo = 1'b1;
    @(posedge clk); #1 param_write_lo = 1'b0;
    param_in = v[63:32]; param_write_hi = 1'b1;
    @(posedge clk); #1 param_write_hi = 1'b0;
  endtask

  task automatic rd64(input int c, input int r, output logic [63:0] v);
    param_addr = 6'(c*16 + r);
    @(posedge clk); #1 v = param_out;
  endtask

  task automatic run_step();
    int n;
    int base [NCH];
    exp_t e;
    logic [63:0] got;
    base = dab_cnt;
    acc_step = 1'b1;
    @(posedge clk); #1 acc_step = 1'b0;
    n = 0;
    while (!done && n < 200) begin @(posedge clk); #1; n++; end
    check("pass_done", {63'b0, done}, 64'd1);
    check("busy_low_at_done", {63'b0, busy}, 64'd0);
    @(negedge clk); #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.r >= 0)            rd64(e.ch, e.r, got);
      else if (e.r == K_SPEED) got = speed[e.ch*SB +: SB];
      else if (e.r == K_SAT)   got = 64'(sat_flags);
      else if (e.r == K_DAB)   got = 64'(dab_cnt[e.ch] - base[e.ch]);
      else                     got = 64'(pending_aborts);
      check(e.tag, got, e.val);
    end
    @(posedge clk); #1;
  endtask

  initial begin : main
    logic [63:0] v;
    int d0, o0;
    logic [63:0] t3_v [4]   = '{64'd700, 64'd400, 64'd100, 64'd0};
    logic [63:0] t3_eff [4] = '{64'd850, 64'd550, 64'd250, 64'd50};
    logic [63:0] t3_pend [4] = '{64'd2, 64'd2, 64'd2, 64'd0};
    logic [63:0] t3_dab [4] = '{64'd0, 64'd0, 64'd0, 64'd1};

    #1;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_speed", {63'b0, |speed}, 64'd0);
    check("rst_sat", 64'(sat_flags), 64'd0);
    check("rst_pending", 64'(pending_aborts), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    for (int c = 0; c < NCH; c++)
      for (int r = 0; r < 16; r++) wr64(c, r, 64'd0);

    // 1: pure jerk integration on ch0
    wr64(0, 6, 64'd10); wr64(0, 0, 64'd1);
    push("t1_vout1", 0, 3, 64'd10);  push("t1_speed1", 0, K_SPEED, 64'd5);  run_step();
    push("t1_vout2", 0, 3, 64'd40);  push("t1_speed2", 0, K_SPEED, 64'd25); run_step();
    push("t1_vout3", 0, 3, 64'd100); push("t1_speed3", 0, K_SPEED, 64'd70);
    push("t1_vin3", 0, 2, 64'd40);   push("t1_a3", 0, 4, 64'd60);            run_step();

    // 2: target velocity stop on ch2
    wr64(0, 0, 64'd0);
    wr64(2, 3, 64'd90); wr64(2, 4, 64'd20); wr64(2, 7, 64'd100); wr64(2, 0, 64'd3);
    push("t2_vout", 2, 3, 64'd100); push("t2_a", 2, 4, 64'd0);
    push("t2_j", 2, 5, 64'd0);      push("t2_jj", 2, 6, 64'd0);
    push("t2_veff", 2, 1, 64'd95);  push("t2_speed2", 2, K_SPEED, 64'd95);
    push("t2_speed0_hold", 0, K_SPEED, 64'd70);
    run_step();

    // 3: host abort with ABORT_A on ch1
    wr64(2, 0, 64'd0);
    wr64(1, 3, 64'd1000); wr64(1, 8, 64'd300); wr64(1, 0, 64'd1);
    abort = 4'b0010;
    @(posedge clk); #1 abort = '0;
    check("t3_pending_set", 64'(pending_aborts), 64'd2);
    for (int s = 0; s < 4; s++) begin
      if (s == 0) begin
        push("t3_status", 1, 0, 64'd3);
        push("t3_a", 1, 4, -64'sd300);
      end
      push($sformatf("t3_vout%0d", s), 1, 3, t3_v[s]);
      push($sformatf("t3_speed%0d", s), 1, K_SPEED, t3_eff[s]);
      push($sformatf("t3_pend%0d", s), 1, K_PEND, t3_pend[s]);
      push($sformatf("t3_dab%0d", s), 1, K_DAB, t3_dab[s]);
      run_step();
    end

    // 4: positive saturation on ch3, then sat_clear
    wr64(1, 0, 64'd0);
    wr64(3, 3, 64'h7fff_ffff_ffff_fffb); wr64(3, 4, 64'd100); wr64(3, 0, 64'd1);
    push("t4_vout", 3, 3, 64'h7fff_ffff_ffff_ffff);
    push("t4_sat", 3, K_SAT, 64'd8);
    push("t4_speed3", 3, K_SPEED, 64'h7fff_ffff_ffff_fffd);
    run_step();
    sat_clear = 1'b1;
    @(posedge clk); #1 sat_clear = 1'b0;
    check("t4_sat_clear", 64'(sat_flags), 64'd0);

    // 5: overlapping acc_step is dropped
    wr64(3, 0, 64'd0);
    wr64(0, 3, 64'd0); wr64(0, 4, 64'd5); wr64(0, 5, 64'd0); wr64(0, 6, 64'd0); wr64(0, 0, 64'd1);
    d0 = done_cnt; o0 = ovr_cnt;
    acc_step = 1'b1;
    @(posedge clk); #1 acc_step = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 acc_step = 1'b1;
    @(posedge clk); #1 acc_step = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("t5_overrun_cnt", 64'(ovr_cnt - o0), 64'd1);
    check("t5_done_cnt", 64'(done_cnt - d0), 64'd1);
    rd64(0, 3, v);
    check("t5_vout_single", v, 64'd5);

    // 6: reset in the middle of a pass
    acc_step = 1'b1;
    @(posedge clk); #1 acc_step = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1 abort = 4'b1000;
    @(posedge clk); #1 abort = '0;
    check("t6_pending_pre", 64'(pending_aborts), 64'd8);
    check("t6_busy_pre", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy", {63'b0, busy}, 64'd0);
    check("t6_done", {63'b0, done}, 64'd0);
    check("t6_overrun", {63'b0, step_overrun}, 64'd0);
    check("t6_speed", {63'b0, |speed}, 64'd0);
    check("t6_pending", 64'(pending_aborts), 64'd0);
    check("t6_dab", 64'(done_aborts), 64'd0);
    check("t6_sat", 64'(sat_flags), 64'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    wr64(0, 3, 64'd0); wr64(0, 4, 64'd7); wr64(0, 5, 64'd0); wr64(0, 6, 64'd0); wr64(0, 0, 64'd1);
    push("t6_vout", 0, 3, 64'd7);
    push("t6_vin", 0, 2, 64'd0);
    push("t6_speed0", 0, K_SPEED, 64'd3);
    push("t6_speed3", 3, K_SPEED, 64'd0);
    push("t6_pend_after", 0, K_PEND, 64'd0);
    run_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
